btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
Parametrised N-channel button conditioner: per-channel 2-FF synchroniser, integrating debounce on a shared sample tick, and press/release/long-press event pulses. Replaces single-button debouncers in front of the stopwatch/watch control FSMs. One instance serves all front-panel buttons. All event outputs are one `clk` cycle wide and are consumed directly by `clk`-domain FSMs.

Parameters:
N_BTN, 5, number of independent button channels
TICK_DIV, 1000, `clk` cycles per sample tick (100 MHz -> 100 kHz)
SAMPLES, 8, consecutive disagreeing samples required to flip the debounced level (>= 2)
LONG_TICKS, 50000, ticks of continuous hold before a long-press event (500 ms)
REPEAT_TICKS, 10000, ticks between auto-repeat pulses (100 ms; used only with the optional feature)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous, active-high
i_btn  in  N_BTN  raw asynchronous button inputs, active-high
o_level  out  N_BTN  debounced level per channel
o_press  out  N_BTN  1-cycle pulse on debounced 0->1 (plus repeats, see Optional Feature)
o_release  out  N_BTN  1-cycle pulse on debounced 1->0
o_long  out  N_BTN  1-cycle pulse when hold reaches LONG_TICKS

Behaviour:
- Reset (async, `rst`=1): tick counter, synchronisers, all per-channel counters cleared; state = IDLE; all outputs 0. No events are emitted for buttons already held at reset release; the level rises only after normal debounce.
- Tick: shared counter runs 0..TICK_DIV-1; `tick` is high for the single cycle in which count == TICK_DIV-1. The first tick occurs TICK_DIV cycles after reset release. The period is exactly TICK_DIV cycles.
- Sync: `s[i]` = `i_btn[i]` delayed through 2 flops.
- Integrator per channel (counter width `$clog2(SAMPLES)`, minimum 1):
  - On tick with `s` == `o_level`: counter <= 0.
  - On tick with `s` != `o_level` and counter < SAMPLES-1: counter +1.
  - On tick with `s` != `o_level` and counter == SAMPLES-1: `o_level` toggles and counter <= 0.
  - Result: the level flips on the SAMPLES-th consecutive disagreeing tick. A single agreeing sample restarts the count (glitch rejection).
- Events: `o_press`/`o_release` are high in exactly the cycle in which `o_level` first shows its new value, i.e. registered together with it.
- Per-channel FSM:
  - IDLE (level 0): on rise -> PRESSED; hold counter <= 0.
  - PRESSED: each tick increments the hold counter. When it reaches LONG_TICKS: `o_long` pulses once -> HELD.
  - HELD: no further `o_long` pulses; the hold counter stops.
  - Any state, on fall: `o_release` pulse -> IDLE; hold counter and repeat counter cleared.
  - A release on the same tick as the long threshold: the release wins; no `o_long` is emitted.
- Counter widths: hold counter `$clog2(LONG_TICKS+1)`, repeat counter `$clog2(REPEAT_TICKS+1)`. Neither wraps; both are bounded by the FSM.
- Channels are fully independent. Simultaneous events on different channels appear in the same cycle on their respective bits.
- Reset asserted mid-operation: immediate return to reset values, with no release pulse.

Optional Feature:
Macro BTN_AUTO_REPEAT_EN.
- Defined: on entry to HELD the repeat counter clears. Each tick in HELD increments it. At REPEAT_TICKS, `o_press` pulses for 1 cycle and the counter clears. Repeats continue until release. The first repeat pulse occurs REPEAT_TICKS ticks after the `o_long` pulse.
- Undefined: the repeat counter and its logic are absent; HELD only waits for release; `o_press` fires only on debounced rise.

Test Plan (bench params: N_BTN=2, TICK_DIV=4, SAMPLES=4, LONG_TICKS=10, REPEAT_TICKS=3):
1. Reset held with `i_btn`=2'b11, then released -> all outputs 0 for the first 3 ticks. `o_level[0]` rises on the 4th tick, with a single `o_press[0]` pulse.
2. `i_btn[0]` asserted cleanly, then released after 6 ticks -> `o_level[0]` high from the 4th sampled tick. Exactly one `o_press` and one `o_release`, each 1 cycle wide. `o_long[0]` stays 0.
3. Glitch: `i_btn[1]` high for 3 ticks, low for 1 tick, high for 3 ticks, then low -> `o_level[1]` never rises; no pulses on channel 1.
4. Hold `i_btn[0]` for 25 ticks -> `o_long[0]` pulses once, 10 ticks after the `o_press` tick. With BTN_AUTO_REPEAT_EN: extra `o_press[0]` pulses 3, 6, 9, 12 ticks after `o_long`. Without the macro: none.
5. Both buttons pressed in the same cycle -> `o_press`=2'b11 in a single cycle. Release `i_btn[1]` only -> `o_release`=2'b10; channel 0 is unaffected.
6. `rst` asserted while channel 0 is in HELD -> outputs 0 asynchronously; no `o_release` pulse. After reset release with the button still held, a fresh `o_press` follows after 4 ticks.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel button conditioner with 2-FF sync, integrating debounce and press/release/long events.
// Define BTN_AUTO_REPEAT_EN to emit repeated o_press pulses every REPEAT_TICKS ticks while a button stays in HELD.
module btn_debounce_multi #(
    parameter int N_BTN        = 5,
    parameter int TICK_DIV     = 1000,
    parameter int SAMPLES      = 8,
    parameter int LONG_TICKS   = 50000,
    parameter int REPEAT_TICKS = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int INT_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [INT_W-1:0]  INT_LAST  = INT_W'(SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(LONG_TICKS);

`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [N_BTN-1:0][REP_W-1:0] r_rep_cnt;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_t;

    logic [TICK_W-1:0]            r_tick_cnt;
    logic                         w_tick;
    logic [N_BTN-1:0]             r_meta;
    logic [N_BTN-1:0]             r_sync;
    logic [N_BTN-1:0][INT_W-1:0]  r_int_cnt;
    logic [N_BTN-1:0][HOLD_W-1:0] r_hold_cnt;
    logic [N_BTN-1:0]             w_flip;
    state_t                       r_state [N_BTN];

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_meta     <= '0;
            r_sync     <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_meta     <= i_btn;
            r_sync     <= r_meta;
        end
    end

    // A flip happens on the SAMPLES-th consecutive disagreeing tick.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_flip[i] = w_tick && (r_sync[i] != o_level[i]) && (r_int_cnt[i] == INT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_level    <= '0;
            o_press    <= '0;
            o_release  <= '0;
            o_long     <= '0;
            r_int_cnt  <= '0;
            r_hold_cnt <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            r_rep_cnt  <= '0;
`endif
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= ST_IDLE;
            end
        end else begin
            o_press   <= '0;
            o_release <= '0;
            o_long    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (w_tick) begin
                    if (r_sync[i] == o_level[i]) begin
                        r_int_cnt[i] <= '0;
                    end else if (w_flip[i]) begin
                        o_level[i]   <= ~o_level[i];
                        r_int_cnt[i] <= '0;
                    end else begin
                        r_int_cnt[i] <= r_int_cnt[i] + 1'b1;
                    end
                end

                // A debounced fall overrides everything, including a coincident long threshold.
                if (w_flip[i] && o_level[i]) begin
                    o_release[i]  <= 1'b1;
                    r_state[i]    <= ST_IDLE;
                    r_hold_cnt[i] <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                    r_rep_cnt[i]  <= '0;
`endif
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            if (w_flip[i]) begin
                                o_press[i]    <= 1'b1;
                                r_state[i]    <= ST_PRESSED;
                                r_hold_cnt[i] <= '0;
                            end
                        end
                        ST_PRESSED: begin
                            if (w_tick) begin
                                if (r_hold_cnt[i] == HOLD_LAST) begin
                                    o_long[i]     <= 1'b1;
                                    r_state[i]    <= ST_HELD;
                                    r_hold_cnt[i] <= HOLD_DONE;
`ifdef BTN_AUTO_REPEAT_EN
                                    r_rep_cnt[i]  <= '0;
`endif
                                end else begin
                                    r_hold_cnt[i] <= r_hold_cnt[i] + 1'b1;
                                end
                            end
                        end
                        ST_HELD: begin
`ifdef BTN_AUTO_REPEAT_EN
                            if (w_tick) begin
                                if (r_rep_cnt[i] == REP_LAST) begin
                                    o_press[i]   <= 1'b1;
                                    r_rep_cnt[i] <= '0;
                                end else begin
                                    r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
                                end
                            end
`endif
                        end
                        default: r_state[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: expected events are queued as stimulus is driven
// and matched, cycle-exact, against every pulse the DUT emits.
module tb_btn_debounce_multi;
    localparam int N_BTN        = 2;
    localparam int TICK_DIV     = 4;
    localparam int SAMPLES      = 4;
    localparam int LONG_TICKS   = 10;
    localparam int REPEAT_TICKS = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] i_btn = '0;
    logic [N_BTN-1:0] o_level;
    logic [N_BTN-1:0] o_press;
    logic [N_BTN-1:0] o_release;
    logic [N_BTN-1:0] o_long;

    btn_debounce_multi #(
        .N_BTN        (N_BTN),
        .TICK_DIV     (TICK_DIV),
        .SAMPLES      (SAMPLES),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_btn     (i_btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; tick t lands on edge TICK_DIV*t.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
        logic [1:0] lvl;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_ev(input int tick, input logic [1:0] press, input logic [1:0] rel,
                             input logic [1:0] lng, input logic [1:0] lvl);
        ev_t e;
        e.cyc   = TICK_DIV * tick;
        e.press = press;
        e.rel   = rel;
        e.lng   = lng;
        e.lvl   = lvl;
        sb.push_back(e);
    endtask

    // Returns one time unit after the edge of tick t; inputs set here are first sampled at tick t+1.
    task automatic goto_tick(input int t);
        while (cyc < TICK_DIV * t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [1:0] btn);
        rst   = 1'b1;
        i_btn = btn;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {o_level, o_press, o_release, o_long}, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst && ((o_press | o_release | o_long) != '0)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {o_press, o_release, o_long}, '0);
            end else begin
                e = sb.pop_front();
                chk("ev_cycle",   cyc,       e.cyc);
                chk("ev_press",   o_press,   e.press);
                chk("ev_release", o_release, e.rel);
                chk("ev_long",    o_long,    e.lng);
                chk("ev_level",   o_level,   e.lvl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: buttons held through reset rise only after normal debounce.
        do_reset(2'b11);
        expect_ev(4, 2'b11, 2'b00, 2'b00, 2'b11);
        goto_tick(3);
        chk("held_at_reset_level_t3", o_level, 2'b00);
        goto_tick(6);
        chk("s1_drain", sb.size(), 0);

        // 2: clean press then release after 6 ticks; no long press.
        do_reset(2'b00);
        goto_tick(1);
        i_btn = 2'b01;
        expect_ev(5, 2'b01, 2'b00, 2'b00, 2'b01);
        goto_tick(7);
        chk("s2_level_held", o_level, 2'b01);
        i_btn = 2'b00;
        expect_ev(11, 2'b00, 2'b01, 2'b00, 2'b00);
        goto_tick(14);
        chk("s2_drain", sb.size(), 0);

        // 3: glitch on channel 1 restarts the integrator; nothing happens.
        do_reset(2'b00);
        goto_tick(1); i_btn = 2'b10;
        goto_tick(4); i_btn = 2'b00;
        goto_tick(5); i_btn = 2'b10;
        goto_tick(8); i_btn = 2'b00;
        goto_tick(12);
        chk("s3_glitch_level", o_level, 2'b00);
        chk("s3_drain", sb.size(), 0);

        // 4: long hold on channel 0.
        do_reset(2'b00);
        goto_tick(1);
        i_btn = 2'b01;
        expect_ev(5,  2'b01, 2'b00, 2'b00, 2'b01);
        expect_ev(15, 2'b00, 2'b00, 2'b01, 2'b01);
`ifdef BTN_AUTO_REPEAT_EN
        expect_ev(18, 2'b01, 2'b00, 2'b00, 2'b01);
        expect_ev(21, 2'b01, 2'b00, 2'b00, 2'b01);
        expect_ev(24, 2'b01, 2'b00, 2'b00, 2'b01);
        expect_ev(27, 2'b01, 2'b00, 2'b00, 2'b01);
`endif
        goto_tick(26);
        i_btn = 2'b00;
        expect_ev(30, 2'b00, 2'b01, 2'b00, 2'b00);
        goto_tick(32);
        chk("s4_drain", sb.size(), 0);

        // 5: simultaneous press, then release of channel 1 only.
        do_reset(2'b00);
        goto_tick(1);
        i_btn = 2'b11;
        expect_ev(5, 2'b11, 2'b00, 2'b00, 2'b11);
        goto_tick(7);
        i_btn = 2'b01;
        expect_ev(11, 2'b00, 2'b10, 2'b00, 2'b01);
        goto_tick(13);
        chk("s5_level", o_level, 2'b01);
        chk("s5_drain", sb.size(), 0);

        // 6: asynchronous reset while channel 0 is in HELD, button kept pressed.
        do_reset(2'b00);
        goto_tick(1);
        i_btn = 2'b01;
        expect_ev(5,  2'b01, 2'b00, 2'b00, 2'b01);
        expect_ev(15, 2'b00, 2'b00, 2'b01, 2'b01);
        goto_tick(16);
        chk("s6_level_before_rst", o_level, 2'b01);
        chk("s6_drain_before_rst", sb.size(), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_rst_outputs", {o_level, o_press, o_release, o_long}, '0);
        do_reset(2'b01);
        expect_ev(4, 2'b01, 2'b00, 2'b00, 2'b01);
        goto_tick(7);
        chk("s6_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
